demux_l1_2a4: RTL and testbench

- Receive-side counterpart of the layer-1 4-to-2 lane multiplexer.
- Takes the two interleaved byte lanes (data_00/valid_00 carrying lanes 0/1, data_11/valid_11 carrying lanes 2/3) at the fast rate. Rebuilds the four parallel byte lanes with their valids, one group every two clock cycles.
- Also flags link idle after a run of empty groups.
- Sits between the lane-merge stage and the four-lane sinks.

---
 rtl/demux_l1_2a4.sv | 110 +++++++++++
 tb/tb_demux_l1_2a4.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/demux_l1_2a4.sv
// Rebuilds four byte lanes from two phase-interleaved lanes; lanes 0/2 appear one edge after capture, lanes 1/3 on their own edge.
// No backpressure: a group is presented every second clk_2f cycle, and idle is flagged after IDLE_GROUPS empty groups.
module demux_l1_2a4 #(
  parameter int BW          = 8,
  parameter int IDLE_GROUPS = 4
) (
  input  logic          clk_2f,
  input  logic          reset,
  input  logic [BW-1:0] data_00,
  input  logic          valid_00,
  input  logic [BW-1:0] data_11,
  input  logic          valid_11,
  output logic [BW-1:0] data_0,
  output logic [BW-1:0] data_1,
  output logic [BW-1:0] data_2,
  output logic [BW-1:0] data_3,
  output logic          valid_0,
  output logic          valid_1,
  output logic          valid_2,
  output logic          valid_3,
  output logic          group_stb,
  output logic          IDLE_OUT
);

  localparam logic [3:0] IDLE_CNT = 4'(IDLE_GROUPS);

  logic                   phase_q, phase_d;
  logic [BW-1:0]          hold_a_q, hold_a_d, hold_b_q, hold_b_d;
  logic                   hva_q, hva_d, hvb_q, hvb_d;
  logic [3:0][BW-1:0]     lane_dat_q, lane_dat_d;
  logic [3:0]             lane_vld_q, lane_vld_d;
  logic                   group_stb_q, group_stb_d;
  logic [3:0]             idle_cnt_q, idle_cnt_d;
  logic                   idle_q, idle_d;
  logic [3:0][BW-1:0]     new_dat;
  logic [3:0]             new_vld;

  always_comb begin
    phase_d     = ~phase_q;
    hold_a_d    = hold_a_q;
    hold_b_d    = hold_b_q;
    hva_d       = hva_q;
    hvb_d       = hvb_q;
    lane_dat_d  = lane_dat_q;
    lane_vld_d  = lane_vld_q;
    group_stb_d = 1'b0;
    idle_cnt_d  = idle_cnt_q;
    idle_d      = idle_q;
    // Bit i of the group vectors is lane i.
    new_vld     = {valid_11, hvb_q, valid_00, hva_q};
    new_dat     = {data_11, hold_b_q, data_00, hold_a_q};

    if (!phase_q) begin
      hold_a_d = data_00;
      hva_d    = valid_00;
      hold_b_d = data_11;
      hvb_d    = valid_11;
    end else begin
      group_stb_d = 1'b1;
      lane_vld_d  = new_vld;
      for (int i = 0; i < 4; i++) begin
        if (new_vld[i]) lane_dat_d[i] = new_dat[i];
      end
      if (new_vld == 4'b0000) begin
        if (idle_cnt_q != IDLE_CNT) idle_cnt_d = idle_cnt_q + 4'd1;
      end else begin
        idle_cnt_d = 4'd0;
      end
      idle_d = (idle_cnt_d == IDLE_CNT);
    end
  end

  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      phase_q     <= 1'b0;
      hold_a_q    <= '0;
      hold_b_q    <= '0;
      hva_q       <= 1'b0;
      hvb_q       <= 1'b0;
      lane_dat_q  <= '0;
      lane_vld_q  <= '0;
      group_stb_q <= 1'b0;
      idle_cnt_q  <= '0;
      idle_q      <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      hold_a_q    <= hold_a_d;
      hold_b_q    <= hold_b_d;
      hva_q       <= hva_d;
      hvb_q       <= hvb_d;
      lane_dat_q  <= lane_dat_d;
      lane_vld_q  <= lane_vld_d;
      group_stb_q <= group_stb_d;
      idle_cnt_q  <= idle_cnt_d;
      idle_q      <= idle_d;
    end
  end

  assign data_0    = lane_dat_q[0];
  assign data_1    = lane_dat_q[1];
  assign data_2    = lane_dat_q[2];
  assign data_3    = lane_dat_q[3];
  assign valid_0   = lane_vld_q[0];
  assign valid_1   = lane_vld_q[1];
  assign valid_2   = lane_vld_q[2];
  assign valid_3   = lane_vld_q[3];
  assign group_stb = group_stb_q;
  assign IDLE_OUT  = idle_q;

endmodule

// File: tb/tb_demux_l1_2a4.sv
// Bench for demux_l1_2a4: hand table, reset corner cases and random round-trip groups.
module tb_demux_l1_2a4;

  localparam int BW          = 8;
  localparam int IDLE_GROUPS = 4;

  logic          clk_2f = 1'b0;
  logic          reset  = 1'b0;
  logic [BW-1:0] data_00 = '0, data_11 = '0;
  logic          valid_00 = 1'b0, valid_11 = 1'b0;
  logic [BW-1:0] data_0, data_1, data_2, data_3;
  logic          valid_0, valid_1, valid_2, valid_3;
  logic          group_stb, IDLE_OUT;

  int n_cmp = 0;
  int n_err = 0;

  // Reference: last valid byte per lane, last group's valids, length of the current empty run.
  logic [3:0][7:0] m_dat;
  logic [3:0]      m_vld;
  int              m_run;

  typedef struct {
    logic [3:0][7:0] d;
    logic [3:0]      v;
    logic [3:0][7:0] ed;
    logic            ei;
  } vec_t;

  vec_t tbl[8];

  demux_l1_2a4 #(.BW(BW), .IDLE_GROUPS(IDLE_GROUPS)) dut (
    .clk_2f(clk_2f), .reset(reset),
    .data_00(data_00), .valid_00(valid_00), .data_11(data_11), .valid_11(valid_11),
    .data_0(data_0), .data_1(data_1), .data_2(data_2), .data_3(data_3),
    .valid_0(valid_0), .valid_1(valid_1), .valid_2(valid_2), .valid_3(valid_3),
    .group_stb(group_stb), .IDLE_OUT(IDLE_OUT)
  );

  always #5 clk_2f = ~clk_2f;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] out_dat();
    return {data_3, data_2, data_1, data_0};
  endfunction

  function automatic logic [3:0] out_vld();
    return {valid_3, valid_2, valid_1, valid_0};
  endfunction

  task automatic model_reset();
    m_dat = '0;
    m_vld = '0;
    m_run = 0;
  endtask

  // Acts as the 4-to-2 mux feeding the DUT, then checks both edges of the group.
  task automatic apply_group(input string nm, input logic [3:0][7:0] d, input logic [3:0] v);
    data_00 = d[0]; valid_00 = v[0]; data_11 = d[2]; valid_11 = v[2];
    @(posedge clk_2f); #1;
    chk({nm, " p0 stb"}, 32'(group_stb), 32'd0);
    chk({nm, " p0 dat"}, out_dat(), m_dat);
    chk({nm, " p0 vld"}, 32'(out_vld()), 32'(m_vld));
    data_00 = d[1]; valid_00 = v[1]; data_11 = d[3]; valid_11 = v[3];
    @(posedge clk_2f); #1;
    for (int i = 0; i < 4; i++) if (v[i]) m_dat[i] = d[i];
    m_vld = v;
    m_run = (v == 4'b0000) ? m_run + 1 : 0;
    chk({nm, " p1 stb"}, 32'(group_stb), 32'd1);
    chk({nm, " p1 dat"}, out_dat(), m_dat);
    chk({nm, " p1 vld"}, 32'(out_vld()), 32'(m_vld));
    chk({nm, " p1 idle"}, 32'(IDLE_OUT), 32'(m_run >= IDLE_GROUPS));
  endtask

  initial begin
    logic [3:0][7:0] rd;
    logic [3:0]      rv;

    tbl[0] = '{d: 32'hCCDDEEFF, v: 4'b1111, ed: 32'hCCDDEEFF, ei: 1'b0};
    tbl[1] = '{d: 32'h33227711, v: 4'b0010, ed: 32'hCCDD77FF, ei: 1'b0};
    tbl[2] = '{d: 32'h01020304, v: 4'b0000, ed: 32'hCCDD77FF, ei: 1'b0};
    tbl[3] = '{d: 32'hA1A2A3A4, v: 4'b0000, ed: 32'hCCDD77FF, ei: 1'b0};
    tbl[4] = '{d: 32'hB1B2B3B4, v: 4'b0000, ed: 32'hCCDD77FF, ei: 1'b0};
    tbl[5] = '{d: 32'hC1C2C3C4, v: 4'b0000, ed: 32'hCCDD77FF, ei: 1'b1};
    tbl[6] = '{d: 32'hD1D2D3D4, v: 4'b0000, ed: 32'hCCDD77FF, ei: 1'b1};
    tbl[7] = '{d: 32'h55446688, v: 4'b1000, ed: 32'h55DD77FF, ei: 1'b0};

    model_reset();
    reset = 1'b0;
    repeat (20) @(posedge clk_2f);
    #1;
    chk("rst dat", out_dat(), 32'h0);
    chk("rst vld", 32'(out_vld()), 32'h0);
    chk("rst stb", 32'(group_stb), 32'd0);
    chk("rst idle", 32'(IDLE_OUT), 32'd0);
    reset = 1'b1;

    // Two empty groups: strobe must sit on the 2nd and 4th edge after release.
    apply_group("start0", '0, 4'b0000);
    apply_group("start1", '0, 4'b0000);
    m_run = 0;

    for (int i = 0; i < 8; i++) begin
      apply_group($sformatf("tbl%0d", i), tbl[i].d, tbl[i].v);
      chk($sformatf("tbl%0d hand dat", i), out_dat(), tbl[i].ed);
      chk($sformatf("tbl%0d hand idle", i), 32'(IDLE_OUT), 32'(tbl[i].ei));
    end

    // Reset right after lane 0 captured 8'hBB: the partial group must vanish.
    data_00 = 8'hBB; valid_00 = 1'b1; data_11 = 8'h00; valid_11 = 1'b0;
    @(posedge clk_2f); #1;
    reset = 1'b0;
    #1;
    chk("midrst dat", out_dat(), 32'h0);
    chk("midrst vld", 32'(out_vld()), 32'h0);
    chk("midrst stb", 32'(group_stb), 32'd0);
    chk("midrst idle", 32'(IDLE_OUT), 32'd0);
    model_reset();
    repeat (2) @(posedge clk_2f);
    #1;
    reset = 1'b1;
    apply_group("postrst", 32'h12345678, 4'b0000);
    chk("postrst no BB", 32'(data_0), 32'h0);

    for (int g = 0; g < 15; g++) begin
      rd = $urandom;
      rv = 4'($urandom);
      if ($urandom_range(0, 3) == 0) rv = 4'b0000;
      apply_group($sformatf("rnd%0d", g), rd, rv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
